// File: rtl/wb_cmd_fifo_if.sv
// Bus bundle for wb_cmd_fifo: Wishbone slave port plus the command stream to the user project.
interface wb_cmd_fifo_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic        overflow_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, cmd_ready_i,
    output wbs_ack_o, wbs_dat_o, cmd_data_o, cmd_valid_o, overflow_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, cmd_ready_i,
    input  wbs_ack_o, wbs_dat_o, cmd_data_o, cmd_valid_o, overflow_o
  );
endinterface

// File: rtl/wb_cmd_fifo.sv
// Wishbone-fed fall-through command FIFO with status/flush register.
// WB_CMD_FIFO_STALL_EN: pushes to a full FIFO stall unacked instead of dropping and flagging overflow.
module wb_cmd_fifo #(
  parameter logic [31:0] ADDRESS_DATA   = 32'h30000300,
  parameter logic [31:0] ADDRESS_STATUS = 32'h30000304,
  parameter int          ABITS          = 3
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  wb_cmd_fifo_if.slave bus
);

  localparam int DEPTH = 2 ** ABITS;
  localparam logic [ABITS:0] DEPTH_CNT = (ABITS + 1)'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS:0]   count;
  logic             overflow;
  logic             ack;
  logic [31:0]      rd_data;

  logic valid;
  logic hit_data;
  logic hit_stat;
  logic push_req;
  logic pop;
  logic full;
  logic empty;
  logic flush;
  logic ovf_clr;
  logic ovf_set;
  logic push_acc;
  logic ack_next;
  logic [31:0] status;

  // ack is masked so a request held through its ack cycle is seen only once
  assign valid    = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack;
  assign hit_data = (bus.wbs_adr_i == ADDRESS_DATA);
  assign hit_stat = (bus.wbs_adr_i == ADDRESS_STATUS);
  assign push_req = valid & bus.wbs_we_i & hit_data & (bus.wbs_sel_i == 4'hF);
  assign flush    = valid & bus.wbs_we_i & hit_stat & bus.wbs_dat_i[1];
  assign ovf_clr  = valid & bus.wbs_we_i & hit_stat & bus.wbs_dat_i[0];
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign pop      = ~empty & bus.cmd_ready_i;
  assign status   = {16'h0000, 8'(count), 5'b00000, overflow, full, empty};

`ifdef WB_CMD_FIFO_STALL_EN
  logic stall;
  assign stall    = push_req & full & ~pop;
  assign push_acc = push_req & ~stall & ~flush;
  assign ovf_set  = 1'b0;
  assign ack_next = valid & (hit_data | hit_stat) & ~stall;
`else
  // a pop in the same cycle frees the slot, so a full-FIFO push is still taken
  assign push_acc = push_req & (~full | pop) & ~flush;
  assign ovf_set  = push_req & full & ~pop & ~flush;
  assign ack_next = valid & (hit_data | hit_stat);
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack      <= 1'b0;
      rd_data  <= 32'h0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      ack <= ack_next;
      if (valid & ~bus.wbs_we_i & (hit_data | hit_stat))
        rd_data <= hit_stat ? status : 32'h0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + 1'b1;
        if (pop)      rd_ptr <= rd_ptr + 1'b1;
        case ({push_acc, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_acc)
      mem[wr_ptr] <= bus.wbs_dat_i;
  end

  assign bus.wbs_ack_o   = ack;
  assign bus.wbs_dat_o   = rd_data;
  assign bus.cmd_data_o  = mem[rd_ptr];
  assign bus.cmd_valid_o = ~empty;
  assign bus.overflow_o  = overflow;

endmodule

// File: tb/tb_wb_cmd_fifo.sv
// Directed self-checking bench for wb_cmd_fifo; follows WB_CMD_FIFO_STALL_EN when defined.
module tb_wb_cmd_fifo;

  localparam logic [31:0] A_DATA = 32'h30000300;
  localparam logic [31:0] A_STAT = 32'h30000304;
  localparam logic [31:0] A_NONE = 32'h30000308;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  wb_cmd_fifo_if bus ();

  wb_cmd_fifo dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge where ack was seen (or budget expired)
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input int budget,
                           output logic got, output logic [31:0] rd, output int lat);
    got = 1'b0;
    rd  = 32'h0;
    lat = 0;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) begin
        got = 1'b1;
        rd  = bus.wbs_dat_o;
        lat = i;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    logic g;
    logic [31:0] r;
    int l;
    wb_access(A_DATA, 1'b1, d, 4'hF, 8, g, r, l);
    chk("push_ack", 32'(g), 32'h1);
  endtask

  task automatic read_status(input logic [31:0] exp, input string tag);
    logic g;
    logic [31:0] r;
    int l;
    wb_access(A_STAT, 1'b0, 32'h0, 4'hF, 8, g, r, l);
    chk("stat_rd_ack", 32'(g), 32'h1);
    chk(tag, r, exp);
  endtask

  initial begin
    logic        got;
    logic [31:0] rd;
    int          lat;

    bus.wbs_cyc_i   = 1'b0;
    bus.wbs_stb_i   = 1'b0;
    bus.wbs_we_i    = 1'b0;
    bus.wbs_sel_i   = 4'h0;
    bus.wbs_dat_i   = 32'h0;
    bus.wbs_adr_i   = 32'h0;
    bus.cmd_ready_i = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat", bus.wbs_dat_o, 32'h0);
    chk("rst_valid", 32'(bus.cmd_valid_o), 32'h0);
    chk("rst_ovf", 32'(bus.overflow_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // first status read: one-cycle latency, empty
    wb_access(A_STAT, 1'b0, 32'h0, 4'hF, 8, got, rd, lat);
    chk("stat0_ack", 32'(got), 32'h1);
    chk("stat0_lat", 32'(lat), 32'h1);
    chk("stat0_val", rd, 32'h00000001);
    chk("stat0_valid", 32'(bus.cmd_valid_o), 32'h0);
    @(negedge clk);
    chk("ack_one_cycle", 32'(bus.wbs_ack_o), 32'h0);

    // three pushes, then drain at one word per cycle
    push(32'hA1);
    push(32'hB2);
    push(32'hC3);
    read_status(32'h00000300, "stat3");
    chk("head_a1", bus.cmd_data_o, 32'hA1);
    chk("valid3", 32'(bus.cmd_valid_o), 32'h1);
    bus.cmd_ready_i = 1'b1;
    @(negedge clk);
    chk("head_b2", bus.cmd_data_o, 32'hB2);
    @(negedge clk);
    chk("head_c3", bus.cmd_data_o, 32'hC3);
    @(negedge clk);
    chk("drained3", 32'(bus.cmd_valid_o), 32'h0);
    bus.cmd_ready_i = 1'b0;

    // fill to depth and push a ninth word
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
`ifdef WB_CMD_FIFO_STALL_EN
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = A_DATA;
    bus.wbs_dat_i = 32'h108;
    bus.wbs_sel_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_no_ack", 32'(bus.wbs_ack_o), 32'h0);
    end
    chk("stall_ovf", 32'(bus.overflow_o), 32'h0);
    bus.cmd_ready_i = 1'b1;
    @(negedge clk);
    chk("stall_ack", 32'(bus.wbs_ack_o), 32'h1);
    bus.cmd_ready_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    read_status(32'h00000802, "stat_stall_full");
    bus.cmd_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("stall_drain", bus.cmd_data_o, 32'h100 + 32'(i));
      @(negedge clk);
    end
`else
    wb_access(A_DATA, 1'b1, 32'h108, 4'hF, 8, got, rd, lat);
    chk("push9_ack", 32'(got), 32'h1);
    chk("ovf_set", 32'(bus.overflow_o), 32'h1);
    read_status(32'h00000806, "stat_ovf");
    wb_access(A_STAT, 1'b1, 32'h1, 4'hF, 8, got, rd, lat);
    chk("clr_ack", 32'(got), 32'h1);
    chk("ovf_clr", 32'(bus.overflow_o), 32'h0);
    read_status(32'h00000802, "stat_full");
    bus.cmd_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain", bus.cmd_data_o, 32'h100 + 32'(i));
      @(negedge clk);
    end
`endif
    chk("drained8", 32'(bus.cmd_valid_o), 32'h0);
    bus.cmd_ready_i = 1'b0;

    // flush with a concurrent ready
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i));
    bus.cmd_ready_i = 1'b1;
    wb_access(A_STAT, 1'b1, 32'h2, 4'hF, 8, got, rd, lat);
    chk("flush_ack", 32'(got), 32'h1);
    chk("flush_valid", 32'(bus.cmd_valid_o), 32'h0);
    bus.cmd_ready_i = 1'b0;
    push(32'h300);
    chk("post_flush_head", bus.cmd_data_o, 32'h300);
    read_status(32'h00000100, "stat_post_flush");

    // partial byte select is acked but not pushed
    wb_access(A_DATA, 1'b1, 32'hDEAD, 4'h3, 8, got, rd, lat);
    chk("sel3_ack", 32'(got), 32'h1);
    read_status(32'h00000100, "stat_sel3");
    chk("sel3_head", bus.cmd_data_o, 32'h300);

    // unmapped address never acked
    wb_access(A_NONE, 1'b0, 32'h0, 4'hF, 4, got, rd, lat);
    chk("unmapped_no_ack", 32'(got), 32'h0);

    // data-address read returns zero
    wb_access(A_DATA, 1'b0, 32'h0, 4'hF, 8, got, rd, lat);
    chk("data_rd_ack", 32'(got), 32'h1);
    chk("data_rd_zero", rd, 32'h0);

    bus.cmd_ready_i = 1'b1;
    @(negedge clk);
    bus.cmd_ready_i = 1'b0;
    chk("drained1", 32'(bus.cmd_valid_o), 32'h0);

    // reset in the middle of a pending request
    push(32'h400);
    read_status(32'h00000100, "stat_pre_rst");
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = 1'b1;
    bus.wbs_adr_i = A_DATA;
    bus.wbs_dat_i = 32'h500;
    bus.wbs_sel_i = 4'hF;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("midrst_valid", 32'(bus.cmd_valid_o), 32'h0);
    chk("midrst_dat", bus.wbs_dat_o, 32'h0);
    chk("midrst_ovf", 32'(bus.overflow_o), 32'h0);
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("postrst_valid", 32'(bus.cmd_valid_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
